// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to BCD converter with multiplexed 4-digit seven-segment drive

module score_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000,
   parameter int STATE_BITS  = 1,
   parameter int STATE_RESET = 0,
   parameter int STATE_PAUSE = 1,
   parameter int STATE_GAME  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [13:0]           score,
   input  logic [STATE_BITS:0]   state,
   output logic [15:0]           bcd,
   output logic                  conv_busy,
   output logic [3:0]            an,
   output logic [6:0]            seg
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [STATE_BITS:0] ST_RESET = (STATE_BITS+1)'(STATE_RESET);
   localparam logic [STATE_BITS:0] ST_PAUSE = (STATE_BITS+1)'(STATE_PAUSE);
   localparam logic [STATE_BITS:0] ST_GAME  = (STATE_BITS+1)'(STATE_GAME);

   typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_LOAD} conv_state_t;

   conv_state_t   cstate_q, cstate_d;
   logic [13:0]   src_q, src_d;
   logic [13:0]   shift_q, shift_d;
   logic [15:0]   work_q, work_d;
   logic [3:0]    iter_q, iter_d;
   logic [15:0]   bcd_q, bcd_d;
   logic          busy_q, busy_d;
   logic [RW-1:0] refresh_q, refresh_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    scan_an_q, scan_an_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;

   logic [13:0]   sat_score;
   logic [15:0]   adj;
   logic [3:0]    cur_digit;
   logic [3:0]    lz;
   logic          pause_mode;

   // Scores above four digits saturate so the display never wraps.
   assign sat_score = (score > 14'd9999) ? 14'd9999 : score;

   // Only pause blinks; reset and game modes always show the scan.
   assign pause_mode = (state == ST_PAUSE) && (state != ST_RESET) && (state != ST_GAME);

   // lz[i]: digit i and every higher digit are zero; the ones digit always shows.
   assign lz[3] = (bcd_q[15:12] == 4'd0);
   assign lz[2] = lz[3] && (bcd_q[11:8] == 4'd0);
   assign lz[1] = lz[2] && (bcd_q[7:4] == 4'd0);
   assign lz[0] = 1'b0;

   assign cur_digit = bcd_q[{idx_q, 2'b00} +: 4];

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // Shift-add-3 converter: capture in IDLE, 14 iterations in SHIFT, publish in LOAD.
   always_comb begin
      cstate_d = cstate_q;
      src_d    = src_q;
      shift_d  = shift_q;
      work_d   = work_q;
      iter_d   = iter_q;
      bcd_d    = bcd_q;
      busy_d   = busy_q;
      adj      = work_q;
      case (cstate_q)
         C_IDLE: begin
            if (sat_score != src_q) begin
               src_d    = sat_score;
               shift_d  = sat_score;
               work_d   = 16'd0;
               iter_d   = 4'd0;
               busy_d   = 1'b1;
               cstate_d = C_SHIFT;
            end
         end
         C_SHIFT: begin
            for (int i = 0; i < 4; i++) begin
               if (adj[4*i +: 4] >= 4'd5) begin
                  adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
               end
            end
            {work_d, shift_d} = {adj, shift_q} << 1;
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'd13) begin
               cstate_d = C_LOAD;
            end
         end
         C_LOAD: begin
            bcd_d    = work_q;
            busy_d   = 1'b0;
            cstate_d = C_IDLE;
         end
         default: cstate_d = C_IDLE;
      endcase
   end

   // Digit scan, leading-zero blanking and pause blink; an/seg change together with the index.
   always_comb begin
      refresh_d   = refresh_q + 1'b1;
      idx_d       = idx_q;
      scan_an_d   = scan_an_q;
      seg_d       = seg_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_on_d  = blink_on_q;
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
         scan_an_d = ~(4'b0001 << idx_q);
         seg_d     = lz[idx_q] ? 7'b1111111 : seg_decode(cur_digit);
      end
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end
      an_d = (pause_mode && !blink_on_d) ? 4'b1111 : scan_an_d;
   end

   // All state registers; async reset puts the display dark and the converter idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cstate_q    <= C_IDLE;
         src_q       <= 14'd0;
         shift_q     <= 14'd0;
         work_q      <= 16'd0;
         iter_q      <= 4'd0;
         bcd_q       <= 16'd0;
         busy_q      <= 1'b0;
         refresh_q   <= '0;
         idx_q       <= 2'd0;
         scan_an_q   <= 4'b1111;
         an_q        <= 4'b1111;
         seg_q       <= 7'b1111111;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else begin
         cstate_q    <= cstate_d;
         src_q       <= src_d;
         shift_q     <= shift_d;
         work_q      <= work_d;
         iter_q      <= iter_d;
         bcd_q       <= bcd_d;
         busy_q      <= busy_d;
         refresh_q   <= refresh_d;
         idx_q       <= idx_d;
         scan_an_q   <= scan_an_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
      end
   end

   assign bcd       = bcd_q;
   assign conv_busy = busy_q;
   assign an        = an_q;
   assign seg       = seg_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard bench for score_display

module tb_score_display;

   localparam int RD = 4;
   localparam int BD = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] score;
   logic [1:0]  state;
   logic [15:0] bcd;
   logic        conv_busy;
   logic [3:0]  an;
   logic [6:0]  seg;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic [6:0]  seg_tab [0:9];

   score_display #(
      .REFRESH_DIV(RD),
      .BLINK_DIV(BD),
      .STATE_BITS(1),
      .STATE_RESET(0),
      .STATE_PAUSE(1),
      .STATE_GAME(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .score(score),
      .state(state),
      .bcd(bcd),
      .conv_busy(conv_busy),
      .an(an),
      .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
      logic [15:0] hi;
      hi = v >> (4 * i);
      if (i != 0 && hi == 16'd0) return 7'b1111111;
      return seg_tab[v[4*i +: 4]];
   endfunction

   // Waits for one conversion to finish, then pops and compares its expected value.
   task automatic wait_done(input string tag, input int budget);
      bit seen = 0;
      bit done = 0;
      logic [15:0] e;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         if (conv_busy) seen = 1;
         else if (seen) done = 1;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_qsize"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_bcd"}, bcd, e);
      end
   endtask

   task automatic do_conv(input logic [13:0] v, input logic [15:0] e, input string tag);
      @(negedge clk);
      score = v;
      exp_q.push_back(e);
      wait_done(tag, 64);
   endtask

   // Syncs to a fresh ones-digit frame and checks all four digits of one scan.
   task automatic scan_check(input logic [15:0] v, input string tag);
      bit gone = 0;
      bit found = 0;
      logic [3:0] ea;
      for (int k = 0; k < 24 && !gone; k++) begin
         @(negedge clk);
         if (an !== 4'b1110) gone = 1;
      end
      for (int k = 0; k < 24 && !found; k++) begin
         @(negedge clk);
         if (an === 4'b1110) found = 1;
      end
      check({tag, "_sync"}, found, 1);
      if (found) begin
         for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (RD) @(negedge clk);
            ea = ~(4'b0001 << i);
            check({tag, "_an"}, an, ea);
            check({tag, "_seg"}, seg, exp_seg(v, i));
         end
      end
   endtask

   initial begin
      bit ok;
      int nf;
      logic [15:0] e;
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
      rst = 1'b1;
      score = 14'd0;
      state = 2'd0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 7'b1111111);
      check("rst_bcd", bcd, 16'h0000);
      check("rst_busy", conv_busy, 1'b0);
      rst = 1'b0;

      // score 0 after reset: no conversion, only "0" shown
      nf = 0;
      repeat (12) begin
         @(negedge clk);
         if (conv_busy) nf++;
      end
      check("idle_no_conv", nf, 0);
      scan_check(16'h0000, "zero");

      // exact latency for 0 -> 1234
      @(negedge clk);
      score = 14'd1234;
      exp_q.push_back(16'h1234);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check("lat_busy", conv_busy, k < 16);
         if (k == 15) check("lat_bcd_hold", bcd, 16'h0000);
      end
      e = exp_q.pop_front();
      check("lat_bcd", bcd, e);
      scan_check(16'h1234, "s1234");

      // saturation and extremes
      state = 2'd2;
      do_conv(14'h3FFF, 16'h9999, "sat");
      do_conv(14'd0, 16'h0000, "back0");
      do_conv(14'd9999, 16'h9999, "max");

      // overwrite during conversion: both values come out in order
      @(negedge clk);
      score = 14'd7;
      exp_q.push_back(16'h0007);
      repeat (5) @(negedge clk);
      score = 14'd1200;
      exp_q.push_back(16'h1200);
      wait_done("mid7", 64);
      wait_done("mid1200", 32);
      do_conv(14'd7, 16'h0007, "seven");
      scan_check(16'h0007, "s7");

      // pause blink: find a fresh blank phase, then check its length and the lit phase
      state = 2'd1;
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); if (an === 4'b1111) ok = 1; end
      check("pause_first_blank", ok, 1);
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); if (an !== 4'b1111) ok = 1; end
      check("pause_lit", ok, 1);
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); if (an === 4'b1111) ok = 1; end
      check("pause_blank_start", ok, 1);
      repeat (15) @(negedge clk);
      check("pause_blank_end", an, 4'b1111);
      @(negedge clk);
      check("pause_lit_start", (an === 4'b1110) || (an === 4'b1101) || (an === 4'b1011) || (an === 4'b0111), 1);
      repeat (15) @(negedge clk);
      check("pause_lit_end", an !== 4'b1111, 1);
      @(negedge clk);
      check("pause_reblank", an, 4'b1111);

      // game mode: never forced dark
      state = 2'd2;
      nf = 0;
      repeat (40) begin
         @(negedge clk);
         if (an === 4'b1111) nf++;
      end
      check("game_no_blank", nf, 0);

      // reset during SHIFT aborts; fresh conversion afterwards
      @(negedge clk);
      score = 14'd555;
      repeat (5) @(negedge clk);
      check("abort_in_shift", conv_busy, 1'b1);
      rst = 1'b1;
      #1;
      check("abort_an", an, 4'b1111);
      check("abort_seg", seg, 7'b1111111);
      check("abort_bcd", bcd, 16'h0000);
      check("abort_busy", conv_busy, 1'b0);
      score = 14'd42;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(16'h0042);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 15) check("rel_bcd_hold", bcd, 16'h0000);
      end
      e = exp_q.pop_front();
      check("rel_bcd", bcd, e);
      check("rel_busy", conv_busy, 1'b0);
      check("q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
